// File: rtl/inst_rom_loader_if.sv
// Byte-stream handshake carrying the program image into the instruction ROM loader.
// A byte transfers on a rising edge where rx_valid && rx_ready; rx_valid may drop at any time.
interface inst_rom_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM that is loaded from a byte stream after reset and then serves the CPU.
// Holds the CPU in reset until the image (16-bit count, then hi/lo word pairs) is complete.
module inst_rom_loader #(
  parameter int ADDR_W = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                skip_load,
  inst_rom_loader_if.slave    rx,
  input  logic [15:0]         pc,
  output logic [15:0]         inst,
  output logic                cpu_reset,
  output logic                load_done,
  output logic                load_err,
  output logic [15:0]         word_count,
  output logic [2:0]          fsm_state
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    RUN     = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] n_words;
  logic [7:0]  hi_byte;
  logic [15:0] mem [DEPTH];

  logic        xfer;
  logic        wr_en;
  logic [15:0] next_count;
  logic [15:0] hdr_value;
  logic        pc_unused;

  assign rx.rx_ready = (state != RUN) && !reset;
  assign xfer        = rx.rx_valid && rx.rx_ready;
  assign next_count  = word_count + 16'd1;
  assign hdr_value   = {n_words[15:8], rx.rx_data};

  // Words past the ROM depth are still counted so the stream stays in step.
  assign wr_en = xfer && (state == DATA_LO) && ({1'b0, word_count} < DEPTH17);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_count[ADDR_W-1:0]] <= {hi_byte, rx.rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= skip_load ? RUN : HDR_HI;
      word_count <= 16'd0;
      load_err   <= 1'b0;
      n_words    <= 16'd0;
      hi_byte    <= 8'd0;
    end else if (xfer) begin
      case (state)
        HDR_HI: begin
          n_words <= {rx.rx_data, 8'h00};
          state   <= HDR_LO;
        end
        HDR_LO: begin
          n_words <= hdr_value;
          if (hdr_value == 16'd0) begin
            state <= RUN;
          end else begin
            state <= DATA_HI;
            if ({1'b0, hdr_value} > DEPTH17) load_err <= 1'b1;
          end
        end
        DATA_HI: begin
          hi_byte <= rx.rx_data;
          state   <= DATA_LO;
        end
        DATA_LO: begin
          word_count <= next_count;
          state      <= (next_count == n_words) ? RUN : DATA_HI;
        end
        default: state <= state;
      endcase
    end
  end

  assign load_done = (state == RUN) && !reset;
  assign cpu_reset = reset || (state != RUN);
  assign inst      = load_done ? mem[pc[ADDR_W-1:0]] : 16'h0000;
  assign fsm_state = state;
  // Upper pc bits are deliberately ignored so fetches wrap around the ROM.
  assign pc_unused = &{1'b0, pc};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: two instances (default depth and a 4-word ROM) share one
// stimulus stream and are compared every cycle against a byte-index model of the image.
module tb_inst_rom_loader;

  localparam int DEPTH_A = 32768;
  localparam int DEPTH_B = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        skip_load = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] pc = 16'h0000;

  logic [15:0] inst_a, inst_b, word_count_a, word_count_b;
  logic        cpu_reset_a, cpu_reset_b, load_done_a, load_done_b, load_err_a, load_err_b;
  logic [2:0]  fsm_state_a, fsm_state_b;

  inst_rom_loader_if rx_a ();
  inst_rom_loader_if rx_b ();
  assign rx_a.rx_data  = rx_data;
  assign rx_a.rx_valid = rx_valid;
  assign rx_b.rx_data  = rx_data;
  assign rx_b.rx_valid = rx_valid;

  inst_rom_loader #(.ADDR_W(15)) dut_a (
    .clk(clk), .reset(reset), .skip_load(skip_load), .rx(rx_a), .pc(pc),
    .inst(inst_a), .cpu_reset(cpu_reset_a), .load_done(load_done_a),
    .load_err(load_err_a), .word_count(word_count_a), .fsm_state(fsm_state_a)
  );

  inst_rom_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .skip_load(skip_load), .rx(rx_b), .pc(pc),
    .inst(inst_b), .cpu_reset(cpu_reset_b), .load_done(load_done_b),
    .load_err(load_err_b), .word_count(word_count_b), .fsm_state(fsm_state_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Image progress is tracked only as "bytes accepted since reset" (k) and the declared count n.
  bit          armed = 1'b0;
  bit          running = 1'b0;
  int          k = 0;
  int          n = 0;
  logic [7:0]  hi_m = 8'h00;
  logic [15:0] mem_a [DEPTH_A];
  bit          vld_a [DEPTH_A];
  logic [15:0] mem_b [DEPTH_B];
  bit          vld_b [DEPTH_B];

  always @(posedge clk) begin
    if (reset) begin
      running = skip_load;
      k = 0;
      n = 0;
      armed = 1'b1;
    end else if (!running && rx_valid) begin
      if (k == 0) begin
        n = int'(rx_data) * 256;
      end else if (k == 1) begin
        n = n + int'(rx_data);
        if (n == 0) running = 1'b1;
      end else if (k % 2 == 0) begin
        hi_m = rx_data;
      end else begin
        int idx;
        idx = (k - 2) / 2;
        if (idx < DEPTH_A) begin mem_a[idx] = {hi_m, rx_data}; vld_a[idx] = 1'b1; end
        if (idx < DEPTH_B) begin mem_b[idx] = {hi_m, rx_data}; vld_b[idx] = 1'b1; end
        if (idx + 1 == n) running = 1'b1;
      end
      k++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (armed) begin
      bit   exp_run;
      int   exp_wc;
      int   ia, ib;
      exp_run = running && !reset;
      exp_wc  = (k < 2) ? 0 : (k - 2) / 2;
      ia = int'(pc) % DEPTH_A;
      ib = int'(pc) % DEPTH_B;
      check("cpu_reset_a", 32'(cpu_reset_a), 32'(!exp_run));
      check("cpu_reset_b", 32'(cpu_reset_b), 32'(!exp_run));
      check("rx_ready_a", 32'(rx_a.rx_ready), 32'(!reset && !running));
      check("rx_ready_b", 32'(rx_b.rx_ready), 32'(!reset && !running));
      check("load_done_a", 32'(load_done_a), 32'(exp_run));
      check("load_done_b", 32'(load_done_b), 32'(exp_run));
      check("word_count_a", 32'(word_count_a), 32'(exp_wc));
      check("word_count_b", 32'(word_count_b), 32'(exp_wc));
      check("load_err_a", 32'(load_err_a), 32'(k >= 2 && n > DEPTH_A));
      check("load_err_b", 32'(load_err_b), 32'(k >= 2 && n > DEPTH_B));
      if (!exp_run) begin
        check("inst_masked_a", 32'(inst_a), 32'h0);
        check("inst_masked_b", 32'(inst_b), 32'h0);
      end else begin
        if (vld_a[ia]) check("inst_a", 32'(inst_a), 32'(mem_a[ia]));
        if (vld_b[ib]) check("inst_b", 32'(inst_b), 32'(mem_b[ib]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] rand_pc();
    logic [15:0] p;
    p = 16'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) p[15] = 1'b1;
    return p;
  endfunction

  task automatic do_reset(input bit skip);
    reset = 1'b1;
    skip_load = skip;
    rx_valid = 1'($urandom_range(0, 1));
    rx_data = 8'($urandom);
    @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset_a), 32'h1);
    check("rst_rx_ready", 32'(rx_a.rx_ready), 32'h0);
    check("rst_inst", 32'(inst_b), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    skip_load = 1'($urandom_range(0, 1));
    rx_valid = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] bytes[$], input bit gaps);
    foreach (bytes[i]) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
        pc = rand_pc();
        @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data = bytes[i];
      pc = rand_pc();
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int cycles, input bit offer);
    repeat (cycles) begin
      rx_valid = offer ? 1'b1 : 1'($urandom_range(0, 1));
      rx_data = 8'($urandom);
      pc = rand_pc();
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic sweep(input int count);
    for (int i = 0; i < count; i++) begin
      pc = 16'(i);
      @(negedge clk);
      check("sweep_inst_a", 32'(inst_a), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] img[$];
  logic [7:0] normal_img[$] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};

  initial begin
    do_reset(1'b0);

    // Normal load at one byte per cycle: CPU held in reset for exactly 8 cycles.
    foreach (normal_img[i]) begin
      rx_valid = 1'b1;
      rx_data = normal_img[i];
      @(negedge clk);
      check("cpu_reset_during_load", 32'(cpu_reset_a), 32'h1);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    @(negedge clk);
    check("cpu_reset_released", 32'(cpu_reset_a), 32'h0);
    check("normal_word_count", 32'(word_count_a), 32'd3);
    check("normal_load_done", 32'(load_done_a), 32'h1);
    @(posedge clk); #1;
    exp_q.push_back(16'h1234); exp_q.push_back(16'hABCD); exp_q.push_back(16'h0007);
    sweep(3);

    // Same image with random gaps.
    do_reset(1'b0);
    send_image(normal_img, 1'b1);
    exp_q.push_back(16'h1234); exp_q.push_back(16'hABCD); exp_q.push_back(16'h0007);
    sweep(3);

    // Empty image.
    do_reset(1'b0);
    img = '{8'h00, 8'h00};
    send_image(img, 1'b0);
    @(negedge clk);
    check("empty_load_done", 32'(load_done_a), 32'h1);
    check("empty_word_count", 32'(word_count_a), 32'd0);
    check("empty_load_err", 32'(load_err_a), 32'h0);
    @(posedge clk); #1;

    // Overflow on the 4-word instance: 6 words declared.
    do_reset(1'b0);
    img = '{8'h00, 8'h06};
    for (int i = 1; i <= 6; i++) begin
      img.push_back(8'(i * 17)); img.push_back(8'(i * 17));
    end
    send_image(img, 1'b1);
    pc = 16'd4;
    @(negedge clk);
    check("ovf_err_b", 32'(load_err_b), 32'h1);
    check("ovf_err_a", 32'(load_err_a), 32'h0);
    check("ovf_count_b", 32'(word_count_b), 32'd6);
    check("ovf_wrap_b", 32'(inst_b), 32'h1111);
    @(posedge clk); #1;
    pc = 16'd5;
    @(negedge clk);
    check("ovf_word5_a", 32'(inst_a), 32'h6666);
    @(posedge clk); #1;

    // Reset mid-load after 2 of 3 words, then skip_load.
    do_reset(1'b0);
    img = '{8'h00, 8'h03, 8'hAA, 8'h01, 8'hAA, 8'h02};
    send_image(img, 1'b0);
    do_reset(1'b0);
    @(negedge clk);
    check("midreset_count", 32'(word_count_a), 32'd0);
    check("midreset_ready", 32'(rx_a.rx_ready), 32'h1);
    @(posedge clk); #1;
    do_reset(1'b1);
    @(negedge clk);
    check("skip_load_done", 32'(load_done_a), 32'h1);
    check("skip_cpu_reset", 32'(cpu_reset_b), 32'h0);
    @(posedge clk); #1;
    exp_q.push_back(16'hAA01); exp_q.push_back(16'hAA02); exp_q.push_back(16'h3333);
    sweep(3);

    // RUN ignores offered bytes.
    idle(10, 1'b1);
    exp_q.push_back(16'hAA01); exp_q.push_back(16'hAA02);
    sweep(2);

    // Randomized images, random gaps, occasional truncation or skip.
    for (int it = 0; it < 25; it++) begin
      int nw;
      int cut;
      nw = int'($urandom_range(0, 8));
      img = '{8'(nw >> 8), 8'(nw)};
      for (int w = 0; w < nw; w++) begin
        img.push_back(8'($urandom)); img.push_back(8'($urandom));
      end
      if ($urandom_range(0, 4) == 0) begin
        do_reset(1'b1);
      end else begin
        do_reset(1'b0);
        if ($urandom_range(0, 3) == 0) begin
          cut = int'($urandom_range(0, img.size() - 1));
          while (img.size() > cut) void'(img.pop_back());
        end
        send_image(img, 1'b1);
      end
      idle(8, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction-memory stage directly upstream of the CPU. It holds the program ROM and supplies `inst` for the CPU's current `pc`. It also owns the CPU's reset. After system reset it receives a program image over an 8-bit valid/ready byte stream, writes it into the ROM, and keeps the CPU in reset until the image is complete. It then releases the CPU and serves instructions combinationally, like the original fixed ROM.

## Interface
- `ADDR_W`, default 15: ROM address width; depth = 2^ADDR_W words of 16 bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `skip_load`  in  1: sampled only in reset cycles. 1 means go straight to RUN with the existing ROM contents.
- `rx_data`  in  8: program byte stream.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader accepts a byte. A byte transfers on an edge where `rx_valid && rx_ready`.
- `pc`  in  16: program counter from the CPU.
- `inst`  out  16: instruction to the CPU.
- `cpu_reset`  out  1: drives the CPU `reset` input.
- `load_done`  out  1: high in RUN.
- `load_err`  out  1: sticky flag; the image declared more words than the ROM depth.
- `word_count`  out  16: number of data words accepted so far.

## Operation
- **Stream format:** 16-bit word count N, high byte first, then N words, each sent high byte then low byte.
- **States:** HDR_HI, HDR_LO, DATA_HI, DATA_LO, RUN.
- **HDR_HI:** on accept, latch N[15:8] and go to HDR_LO.
- **HDR_LO:** on accept, latch N[7:0].
  - If {N[15:8], byte} == 0, go to RUN.
  - Otherwise go to DATA_HI, and set `load_err` if that value > 2^ADDR_W.
- **DATA_HI:** on accept, latch the high byte and go to DATA_LO.
- **DATA_LO:** on accept, write mem[`word_count`[ADDR_W-1:0]] <= {hi, byte} and increment `word_count`.
  - Words at index ≥ 2^ADDR_W are consumed but not written.
  - If the new count == N, go to RUN; otherwise go to DATA_HI.
- **RUN:** terminal. Only `reset` leaves it.
- **Stalls:** no state change on any edge without a transfer. `rx_valid` may drop at any time.
- **`rx_ready`** = (state != RUN) && !`reset`.
- **`cpu_reset`** = `reset` || (state != RUN), combinational. The CPU is reset in every cycle the loader is not in RUN.
- **`inst`** = mem[`pc`[ADDR_W-1:0]] in RUN, combinational read; 16'h0000 otherwise. `pc` bits above ADDR_W are ignored, so the address wraps.
- **`load_done`** = (state == RUN).

## Timing
- **Reset cycle:**
  - state <= RUN if `skip_load`, else HDR_HI.
  - `word_count` <= 0, `load_err` <= 0, N <= 0.
  - ROM contents are untouched.
  - Outputs while `reset` is high: `cpu_reset`=1, `rx_ready`=0, `inst`=0, `load_done`=0.
- **After reset:**
  - Load path: `rx_ready`=1, `cpu_reset`=1, `load_done`=0.
  - With `skip_load`: `cpu_reset`=0 and `load_done`=1 in the first cycle after reset.
- **Throughput:** one byte per cycle; 2 + 2N accepted bytes minimum to RUN.
- **Release latency:**
  - The edge accepting the last low byte writes the ROM and enters RUN.
  - In the next cycle `cpu_reset`=0, `rx_ready`=0, and `inst` = mem[`pc`]. The CPU's first fetch is mem[0].
- **ROM write:** takes effect on the accepting edge. It is readable the following cycle, but `inst` is masked until RUN in any case.
- **Reset mid-load:** partial image stays in the ROM; the loader restarts at HDR_HI and `word_count`=0.
- **Reset in RUN:** the loader reloads unless `skip_load`=1.
- **Bytes offered in RUN:** never accepted (`rx_ready`=0).

## Test plan
- **Normal load:** reset, `skip_load`=0, stream 00 03 | 12 34 | AB CD | 00 07 at one byte/cycle -> `cpu_reset`=1 for exactly 8 cycles after reset; then 0. With `pc`=0/1/2, `inst`=1234/ABCD/0007; `word_count`=3, `load_done`=1.
- **Backpressure / gaps:** same image with `rx_valid` toggled randomly -> identical ROM contents. No byte is lost or duplicated; `word_count` changes only on DATA_LO accepts.
- **Empty image:** 00 00 -> RUN on the edge accepting the second byte; `word_count`=0, `load_err`=0.
- **Overflow (ADDR_W=2):** N=6 -> `load_err`=1 after the header. mem[0..3] hold words 0-3; words 4-5 are consumed but not written; RUN after 14 bytes; `pc`=4 returns mem[0].
- **Reset mid-load, then skip_load:** reset after 2 of 3 words -> HDR_HI, `word_count`=0. Then reset with `skip_load`=1 -> RUN next cycle; `inst` shows the previously written words.
- **RUN ignores stream:** in RUN, drive `rx_valid`=1 for 10 cycles -> `rx_ready`=0, ROM unchanged, `cpu_reset` stays 0.
